exec_mul_sequencer: RTL and testbench



---
 rtl/exec_mul_sequencer.sv | 142 ++++++++++++++
 tb/tb_exec_mul_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/exec_mul_sequencer.sv
// EX-stage multiply sequencer: counts multiplier latency and drives pipeline stall/bubble enables.
// Optional load-use bubble insertion is enabled by defining LOAD_USE_STALL_EN.
module exec_mul_sequencer #(
  parameter int unsigned MUL_LAT = 5,
  parameter logic [6:0]  OPC_MUL = 7'h02,
  parameter logic [6:0]  OPC_NOP = 7'h3F,
  parameter logic [6:0]  OPC_LDW = 7'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_dst,
  input  logic       ex_flush,
  input  logic       id_valid,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  output logic       fetch_en,
  output logic       ex_en,
  output logic       ex_bubble,
  output logic       mem_bubble,
  output logic       mul_start,
  output logic       mul_res_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_BUSY_CNT = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mul_hit;
  logic       load_use_hit;

  assign mul_hit = ex_valid && (ex_opcode == OPC_MUL) && !ex_flush;

`ifdef LOAD_USE_STALL_EN
  assign load_use_hit = ex_valid && (ex_opcode == OPC_LDW) && (ex_dst != 5'd0) &&
                        id_valid && ((id_src1 == ex_dst) || (id_src2 == ex_dst)) &&
                        !ex_flush;
  logic [6:0] unused_opc;
  assign unused_opc = OPC_NOP;
`else
  assign load_use_hit = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{id_valid, id_src1, id_src2, ex_dst, OPC_LDW, OPC_NOP};
`endif

  // A flush in BUSY or DONE abandons the multiply and returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mul_hit) begin
          state_d = BUSY;
          cnt_d   = 4'd1;
        end
      end
      BUSY: begin
        if (ex_flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BUSY_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational; reset forces the free-flowing pipeline pattern even
  // though the registered state only clears on the next edge.
  always_comb begin
    fetch_en      = 1'b1;
    ex_en         = 1'b1;
    ex_bubble     = 1'b0;
    mem_bubble    = 1'b0;
    mul_start     = 1'b0;
    mul_res_valid = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (mul_hit) begin
            mul_start  = 1'b1;
            fetch_en   = 1'b0;
            ex_en      = 1'b0;
            mem_bubble = 1'b1;
          end else if (load_use_hit) begin
            fetch_en  = 1'b0;
            ex_bubble = 1'b1;
          end
        end
        BUSY: begin
          mem_bubble = 1'b1;
          if (!ex_flush) begin
            fetch_en = 1'b0;
            ex_en    = 1'b0;
          end
        end
        DONE: begin
          if (ex_flush) begin
            mem_bubble = 1'b1;
          end else begin
            mul_res_valid = 1'b1;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Directed bench for exec_mul_sequencer (MUL_LAT=5); expected output vectors are hand-derived.
module tb_exec_mul_sequencer;

  logic       clk;
  logic       rst;
  logic       ex_valid;
  logic [6:0] ex_opcode;
  logic [4:0] ex_dst;
  logic       ex_flush;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       fetch_en;
  logic       ex_en;
  logic       ex_bubble;
  logic       mem_bubble;
  logic       mul_start;
  logic       mul_res_valid;
  logic       busy;

  int vectorCount = 0;
  int missCount   = 0;

  // Output vector order: {fetch_en, ex_en, ex_bubble, mem_bubble, mul_start, mul_res_valid, busy}
  localparam logic [6:0] V_RUN   = 7'b1100000;
  localparam logic [6:0] V_START = 7'b0001100;
  localparam logic [6:0] V_BUSY  = 7'b0001001;
  localparam logic [6:0] V_DONE  = 7'b1100011;
  localparam logic [6:0] V_FLUSH = 7'b1101001;
  localparam logic [6:0] V_LDUSE = 7'b0110000;

  localparam logic [6:0] ADD = 7'h00;
  localparam logic [6:0] SUB = 7'h01;
  localparam logic [6:0] MUL = 7'h02;
  localparam logic [6:0] LDW = 7'h10;
  localparam logic [6:0] NOP = 7'h3F;

  exec_mul_sequencer #(.MUL_LAT(5)) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_opcode(ex_opcode),
    .ex_dst(ex_dst),
    .ex_flush(ex_flush),
    .id_valid(id_valid),
    .id_src1(id_src1),
    .id_src2(id_src2),
    .fetch_en(fetch_en),
    .ex_en(ex_en),
    .ex_bubble(ex_bubble),
    .mem_bubble(mem_bubble),
    .mul_start(mul_start),
    .mul_res_valid(mul_res_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs after the falling edge and checks the combinational outputs before the next rising edge.
  task automatic applyStimulus(input string tag, input logic r, input logic v, input logic [6:0] opc,
                               input logic [4:0] dst, input logic fl, input logic idv,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] exp);
    @(negedge clk);
    rst       = r;
    ex_valid  = v;
    ex_opcode = opc;
    ex_dst    = dst;
    ex_flush  = fl;
    id_valid  = idv;
    id_src1   = s1;
    id_src2   = s2;
    #1;
    checkOutput(tag, {fetch_en, ex_en, ex_bubble, mem_bubble, mul_start, mul_res_valid, busy}, exp);
  endtask

  logic [6:0] expLoadUse;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = NOP; ex_dst = 5'd0; ex_flush = 1'b0;
    id_valid = 1'b0; id_src1 = 5'd0; id_src2 = 5'd0;
`ifdef LOAD_USE_STALL_EN
    expLoadUse = V_LDUSE;
`else
    expLoadUse = V_RUN;
`endif

    // Reset with a MUL sitting in EX must not launch anything.
    applyStimulus("reset0", 1, 1, MUL, 5'd1, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("reset1", 1, 1, MUL, 5'd1, 0, 0, 5'd0, 5'd0, V_RUN);

    // Single MUL held in EX.
    applyStimulus("single_start", 0, 1, MUL, 5'd3, 0, 0, 5'd0, 5'd0, V_START);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("single_busy%0d", i), 0, 1, MUL, 5'd3, 0, 0, 5'd0, 5'd0, V_BUSY);
    applyStimulus("single_done", 0, 1, MUL, 5'd3, 0, 0, 5'd0, 5'd0, V_DONE);
    applyStimulus("single_after", 0, 1, ADD, 5'd4, 0, 0, 5'd0, 5'd0, V_RUN);

    // Back-to-back MULs: second one starts immediately after DONE.
    for (int m = 0; m < 2; m++) begin
      applyStimulus($sformatf("b2b%0d_start", m), 0, 1, MUL, 5'd6, 0, 0, 5'd0, 5'd0, V_START);
      for (int i = 0; i < 4; i++)
        applyStimulus($sformatf("b2b%0d_busy%0d", m, i), 0, 1, MUL, 5'd6, 0, 0, 5'd0, 5'd0, V_BUSY);
      applyStimulus($sformatf("b2b%0d_done", m), 0, 1, MUL, 5'd6, 0, 0, 5'd0, 5'd0, V_DONE);
    end
    applyStimulus("b2b_after", 0, 1, SUB, 5'd2, 0, 0, 5'd0, 5'd0, V_RUN);

    // Flush on the third cycle of a MUL.
    applyStimulus("flush_start", 0, 1, MUL, 5'd7, 0, 0, 5'd0, 5'd0, V_START);
    applyStimulus("flush_busy", 0, 1, MUL, 5'd7, 0, 0, 5'd0, 5'd0, V_BUSY);
    applyStimulus("flush_cycle", 0, 1, MUL, 5'd7, 1, 0, 5'd0, 5'd0, V_FLUSH);
    applyStimulus("flush_after", 0, 1, ADD, 5'd7, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("flush_after2", 0, 1, ADD, 5'd7, 0, 0, 5'd0, 5'd0, V_RUN);

    // Flush landing on DONE suppresses the result.
    applyStimulus("fdone_start", 0, 1, MUL, 5'd8, 0, 0, 5'd0, 5'd0, V_START);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("fdone_busy%0d", i), 0, 1, MUL, 5'd8, 0, 0, 5'd0, 5'd0, V_BUSY);
    applyStimulus("fdone_flush", 0, 1, MUL, 5'd8, 1, 0, 5'd0, 5'd0, V_FLUSH);
    applyStimulus("fdone_after", 0, 1, ADD, 5'd8, 0, 0, 5'd0, 5'd0, V_RUN);

    // Reset for one cycle at cnt=2 abandons the multiply.
    applyStimulus("rstbusy_start", 0, 1, MUL, 5'd9, 0, 0, 5'd0, 5'd0, V_START);
    applyStimulus("rstbusy_busy", 0, 1, MUL, 5'd9, 0, 0, 5'd0, 5'd0, V_BUSY);
    applyStimulus("rstbusy_rst", 1, 1, MUL, 5'd9, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("rstbusy_add0", 0, 1, ADD, 5'd9, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("rstbusy_add1", 0, 1, ADD, 5'd9, 0, 0, 5'd0, 5'd0, V_RUN);

    // Non-MUL traffic, an invalid MUL and a flushed MUL in IDLE.
    applyStimulus("nonmul_add", 0, 1, ADD, 5'd1, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("nonmul_sub", 0, 1, SUB, 5'd2, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("nonmul_nop", 0, 1, NOP, 5'd0, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("nonmul_invmul", 0, 0, MUL, 5'd3, 0, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("nonmul_flushmul", 0, 1, MUL, 5'd3, 1, 0, 5'd0, 5'd0, V_RUN);
    applyStimulus("nonmul_after", 0, 1, ADD, 5'd3, 0, 0, 5'd0, 5'd0, V_RUN);

    // Load-use cases.
    applyStimulus("ldu_src2", 0, 1, LDW, 5'd5, 0, 1, 5'd1, 5'd5, expLoadUse);
    applyStimulus("ldu_clear", 0, 1, NOP, 5'd0, 0, 1, 5'd1, 5'd5, V_RUN);
    applyStimulus("ldu_src1", 0, 1, LDW, 5'd12, 0, 1, 5'd12, 5'd3, expLoadUse);
    applyStimulus("ldu_dst0", 0, 1, LDW, 5'd0, 0, 1, 5'd0, 5'd0, V_RUN);
    applyStimulus("ldu_nomatch", 0, 1, LDW, 5'd5, 0, 1, 5'd4, 5'd6, V_RUN);
    applyStimulus("ldu_idinv", 0, 1, LDW, 5'd5, 0, 0, 5'd5, 5'd5, V_RUN);
    applyStimulus("ldu_flush", 0, 1, LDW, 5'd5, 1, 1, 5'd5, 5'd5, V_RUN);

    // No load-use stall while a multiply is in progress.
    applyStimulus("ldu_mulstart", 0, 1, MUL, 5'd5, 0, 1, 5'd5, 5'd5, V_START);
    applyStimulus("ldu_inbusy", 0, 1, LDW, 5'd5, 0, 1, 5'd5, 5'd5, V_BUSY);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
